// File: rtl/pattern_det.sv
// rtl/pattern_det.sv - serial 4-bit frame detector with target match and saturating match counter
module pattern_det #(
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pattern_in,
  input  logic                 valid_in,
  input  logic [FRAME_LEN-1:0] target,
  input  logic                 clr_cnt,
  output logic [FRAME_LEN-1:0] frame,
  output logic                 frame_done,
  output logic                 match,
  output logic                 abort,
  output logic [CNT_W-1:0]     match_cnt
);

  // State name encodes how many bits of the current frame are held.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B1   = 2'd1,
    B2   = 2'd2,
    B3   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [FRAME_LEN-2:0]   shift_q, shift_d;
  logic [FRAME_LEN-1:0]   frame_q, frame_d;
  logic                   frame_done_q, frame_done_d;
  logic                   match_q, match_d;
  logic                   abort_q, abort_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FRAME_LEN-1:0]   complete;
  logic                   hit;

  assign complete = {shift_q, pattern_in};

  // Next-state: frame assembly, completion/abort pulses and counter update.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    frame_d      = frame_q;
    frame_done_d = 1'b0;
    match_d      = 1'b0;
    abort_d      = 1'b0;
    cnt_d        = cnt_q;
    hit          = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_in) begin
          shift_d = {{(FRAME_LEN-2){1'b0}}, pattern_in};
          state_d = B1;
        end
      end
      B1, B2: begin
        if (valid_in) begin
          shift_d = {shift_q[FRAME_LEN-3:0], pattern_in};
          state_d = (state_q == B1) ? B2 : B3;
        end else begin
          // Partial frame dropped: flag it and start over.
          shift_d = '0;
          abort_d = 1'b1;
          state_d = IDLE;
        end
      end
      B3: begin
        shift_d = '0;
        state_d = IDLE;
        if (valid_in) begin
          frame_d      = complete;
          frame_done_d = 1'b1;
          hit          = (complete == target);
          match_d      = hit;
        end else begin
          abort_d = 1'b1;
        end
      end
      default: begin
        shift_d = '0;
        state_d = IDLE;
      end
    endcase

    // Clear takes priority over a coincident match; count saturates.
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State and output registers; reset drops any partial frame without abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      frame_q      <= '0;
      frame_done_q <= 1'b0;
      match_q      <= 1'b0;
      abort_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      frame_q      <= frame_d;
      frame_done_q <= frame_done_d;
      match_q      <= match_d;
      abort_q      <= abort_d;
      cnt_q        <= cnt_d;
    end
  end

  assign frame      = frame_q;
  assign frame_done = frame_done_q;
  assign match      = match_q;
  assign abort      = abort_q;
  assign match_cnt  = cnt_q;

endmodule

// File: doc/pattern_det.md
# pattern_det

Serial frame detector that sits directly downstream of the pattern generator: it samples the 1-bit `pattern`/`valid` stream, assembles 4-bit frames MSB-first, compares each completed frame against a programmable target, and keeps a saturating count of matches. Frames interrupted by `valid` dropping early are discarded and flagged. All outputs are registered.

## Interface
Parameters:
- `FRAME_LEN`, 4: bits per frame; the design is fixed to 4 and must not be changed.
- `CNT_W`, 8: width of the match counter.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `pattern_in`  in  1  serial data bit from the generator.
- `valid_in`  in  1  qualifies `pattern_in` in the same cycle.
- `target`  in  4  frame value to match; sampled in the cycle the 4th bit arrives.
- `clr_cnt`  in  1  synchronous clear of `match_cnt`.
- `frame`  out  4  last completed frame, first-received bit in [3].
- `frame_done`  out  1  one-cycle pulse: `frame` was just updated.
- `match`  out  1  one-cycle pulse, coincident with `frame_done`, when frame == target.
- `abort`  out  1  one-cycle pulse: a partial frame was dropped.
- `match_cnt`  out  CNT_W  number of matched frames, saturating.

## Operation
- FSM states: IDLE (0 bits held), B1, B2, B3 (1, 2, 3 bits held).
- IDLE: `valid_in`=1 -> shift bit into shift reg, go to B1; else stay.
- B1->B2, B2->B3: on `valid_in`=1, shift the bit in.
- B3 with `valid_in`=1: complete frame = {shift[2:0], pattern_in}. Load it into `frame`, set `frame_done`=1, set `match`=(complete == target), go to IDLE.
- B1/B2/B3 with `valid_in`=0: pulse `abort`, discard the shift reg, go to IDLE. `frame`, `match`, and `match_cnt` are unchanged.
- Back-to-back frames: IDLE accepts `valid_in` in the cycle right after completion. No idle gap is required.
- `match_cnt`: increments by 1 on each match. It holds at 2^CNT_W−1 (no wrap).
- `clr_cnt`=1: `match_cnt` becomes 0 next cycle. If a match completes in the same cycle, clear wins and the count is 0.
- `clr_cnt` affects nothing but the counter.
- `target` may change at any time. Only its value in the 4th-bit cycle matters.

## Timing
- Reset (`rst`=1 at an edge): FSM=IDLE, shift reg=0, `frame`=0, `frame_done`=0, `match`=0, `abort`=0, `match_cnt`=0.
- Reset overrides every other input, including `valid_in` and `clr_cnt`.
- Reset mid-frame drops the partial frame silently: no `abort` pulse.
- Latency: the 4th bit sampled at edge N gives `frame`/`frame_done`/`match` valid after edge N. `match_cnt` is updated at the same edge N.
- Abort: `valid_in`=0 sampled in B1–B3 at edge N gives `abort`=1 after edge N, for exactly one cycle.
- `frame_done`, `match`, and `abort` are never high for more than one cycle.
- `abort` and `frame_done` are never high together.
- Upstream generator timing: `en` pulse, then 4 valid cycles carrying {sel[2], sel[2], sel[1], sel[0]}. This yields exactly one `frame_done`, with no `abort`.

## Test plan
- Reset then idle: `rst`=1 for 2 cycles, `valid_in`=0 for 10 cycles -> all outputs 0 throughout.
- Single match: `target`=4'b1101, stream 1,1,0,1 with `valid_in`=1 -> after the 4th edge, `frame`=4'b1101, `frame_done`=1, `match`=1, `match_cnt`=1.
- Mismatch, then back-to-back: `target`=4'b0011, frames 0000 then 0011 on 8 consecutive valid cycles:
  - first `frame_done` has `match`=0;
  - second `frame_done` (4 cycles later) has `match`=1;
  - `match_cnt`=1.
- Abort: valid bits 1,0 then `valid_in`=0 -> `abort`=1 for one cycle, `frame` keeps its prior value, `match_cnt` unchanged. A following full frame 1111 is then detected correctly.
- Counter edges:
  - CNT_W=8, 256 matching frames -> `match_cnt`=255 (saturated, no wrap).
  - `clr_cnt`=1 in the same cycle as a completing match -> `match_cnt`=0.
- Reset mid-frame: `rst` asserted after 2 valid bits -> no `abort`. Post-reset, frame 1001 gives `frame`=4'b1001 with only the new bits counted.
